// File: rtl/instr_type_cycler.sv
// Walks a fixed RV32 opcode table, decodes each entry to a type code and drives board LEDs.
// Define CYCLER_STEP_EN to add a synchronised single-step button that works while paused.
module instr_type_cycler #(
  parameter int unsigned DELAY_COUNT    = 50_000_000,
  parameter int unsigned NUM_INSTR      = 10,
  parameter int unsigned LED_W          = 4,
  parameter int unsigned LED_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             step,
  output logic [LED_W-1:0] led,
  output logic [3:0]       type_code,
  output logic [3:0]       idx,
  output logic             illegal
);

  localparam int unsigned      CntW   = $clog2(DELAY_COUNT);
  localparam logic [CntW-1:0]  CntMax = CntW'(DELAY_COUNT - 1);
  localparam logic [3:0]       IdxMax = 4'(NUM_INSTR - 1);
  localparam logic [LED_W-1:0] LedOff = {LED_W{LED_ACTIVE_LOW != 0}};

  // Table repeats every ten entries; the tenth slot is a deliberately illegal opcode.
  function automatic logic [6:0] opcode_at(input logic [3:0] k);
    logic [3:0] m;
    m = (k >= 4'd10) ? k - 4'd10 : k;
    case (m)
      4'd0:    opcode_at = 7'b0110011;
      4'd1:    opcode_at = 7'b0010011;
      4'd2:    opcode_at = 7'b0100011;
      4'd3:    opcode_at = 7'b0000011;
      4'd4:    opcode_at = 7'b1100011;
      4'd5:    opcode_at = 7'b1101111;
      4'd6:    opcode_at = 7'b1100111;
      4'd7:    opcode_at = 7'b0110111;
      4'd8:    opcode_at = 7'b0010111;
      default: opcode_at = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] decode(input logic [6:0] op);
    case (op)
      7'b0110011: decode = 4'd1;
      7'b0010011: decode = 4'd2;
      7'b0100011: decode = 4'd3;
      7'b0000011: decode = 4'd4;
      7'b1100011: decode = 4'd5;
      7'b1101111: decode = 4'd6;
      7'b1100111: decode = 4'd7;
      7'b0110111: decode = 4'd8;
      7'b0010111: decode = 4'd9;
      default:    decode = 4'd15;
    endcase
  endfunction

  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [3:0]       r_idx, w_idx_d, w_idx_wrap;
  logic [3:0]       r_type, w_type_d;
  logic             r_illegal, w_illegal_d;
  logic [LED_W-1:0] r_led, w_led_d, w_led_raw;
  logic             w_step_edge;

`ifdef CYCLER_STEP_EN
  logic r_step_s1, r_step_s2, r_step_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_s1  <= 1'b0;
      r_step_s2  <= 1'b0;
      r_step_dly <= 1'b0;
    end else begin
      r_step_s1  <= step;
      r_step_s2  <= r_step_s1;
      r_step_dly <= r_step_s2;
    end
  end

  assign w_step_edge = r_step_s2 & ~r_step_dly;
`else
  logic w_unused_step;
  assign w_unused_step = step;
  assign w_step_edge   = 1'b0;
`endif

  assign w_idx_wrap = (r_idx >= IdxMax) ? 4'd0 : r_idx + 4'd1;

  always_comb begin
    w_cnt_d = r_cnt;
    w_idx_d = r_idx;
    if (pause) begin
      w_cnt_d = '0;
      if (w_step_edge) w_idx_d = w_idx_wrap;
    end else if (r_cnt == CntMax) begin
      w_cnt_d = '0;
      w_idx_d = w_idx_wrap;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  // Decode follows r_idx, so outputs lag an index change by one cycle.
  always_comb begin
    w_type_d    = decode(opcode_at(r_idx));
    w_illegal_d = (w_type_d == 4'd15);
    w_led_raw   = '0;
    w_led_raw[3:0] = w_type_d;
    if (LED_W > 4) w_led_raw[LED_W-1] = w_illegal_d;
    w_led_d = (LED_ACTIVE_LOW != 0) ? ~w_led_raw : w_led_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= 4'd0;
      r_type    <= 4'd0;
      r_illegal <= 1'b0;
      r_led     <= LedOff;
    end else begin
      r_cnt     <= w_cnt_d;
      r_idx     <= w_idx_d;
      r_type    <= w_type_d;
      r_illegal <= w_illegal_d;
      r_led     <= w_led_d;
    end
  end

  assign led       = r_led;
  assign type_code = r_type;
  assign idx       = r_idx;
  assign illegal   = r_illegal;

endmodule
